// File: rtl/clock_pkg.sv
// Shared digit widths, counting limits and reset constants for the BCD time-of-day counter.
package clock_pkg;

  localparam int H1_W = 2;
  localparam int M1_W = 3;
  localparam int DIG_W = 4;

  localparam int SEC_TENS_MAX = 5;
  localparam int UNITS_MAX = 9;
  localparam int HOURS24_MAX = 23;
  localparam int HOURS12_MAX = 12;

  localparam logic [H1_W-1:0]  RST24_H1 = 2'd0;
  localparam logic [DIG_W-1:0] RST24_H2 = 4'd0;
  localparam logic [H1_W-1:0]  RST12_H1 = 2'd1;
  localparam logic [DIG_W-1:0] RST12_H2 = 4'd2;
  localparam logic             RST_PM = 1'b0;

  // Binary value of an hours digit pair, used for range checks and wrap detection.
  function automatic int hours_bin(logic [H1_W-1:0] tens, logic [DIG_W-1:0] units);
    return 10 * int'(tens) + int'(units);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX on inc, wraps to 0 and reports a carry on wrap.
module bcd_digit_counter #(
  parameter int W = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] digit,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign carry = inc & (digit == MAX_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= value;
    end else if (inc) begin
      digit <= carry ? '0 : digit + W'(1);
    end
  end

endmodule

// File: rtl/hms_bcd_counter.sv
// Hours/minutes/seconds BCD clock with prescaler, validated load and 12/24-hour display.
module hms_bcd_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter bit MODE_24H = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [H1_W-1:0]  ld_h1,
  input  logic [DIG_W-1:0] ld_h2,
  input  logic [M1_W-1:0]  ld_m1,
  input  logic [DIG_W-1:0] ld_m2,
  input  logic [M1_W-1:0]  ld_s1,
  input  logic [DIG_W-1:0] ld_s2,
  input  logic             ld_pm,
  output logic [H1_W-1:0]  h1,
  output logic [DIG_W-1:0] h2,
  output logic [M1_W-1:0]  m1,
  output logic [DIG_W-1:0] m2,
  output logic [M1_W-1:0]  s1,
  output logic [DIG_W-1:0] s2,
  output logic             pm,
  output logic             sec_tick,
  output logic             day_tick,
  output logic             load_err
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0]    presc;
  logic             tc, ld_ok, hrs_ok, ld_take, adv;
  logic             s2_carry, s1_carry, m2_carry, hour_inc;
  logic [H1_W-1:0]  h1_nxt;
  logic [DIG_W-1:0] h2_nxt;
  logic             pm_q, pm_nxt, day_roll;
  logic             sec_tick_p1, day_tick_p1, load_err_p1;
  int               ld_hours, cur_hours;

  assign ld_hours  = hours_bin(ld_h1, ld_h2);
  assign cur_hours = hours_bin(h1, h2);

  always_comb begin
    hrs_ok = MODE_24H ? (ld_hours <= HOURS24_MAX)
                      : (ld_hours >= 1 && ld_hours <= HOURS12_MAX);
    ld_ok  = hrs_ok && (ld_h2 <= DIG_W'(UNITS_MAX))
          && (ld_m1 <= M1_W'(SEC_TENS_MAX)) && (ld_m2 <= DIG_W'(UNITS_MAX))
          && (ld_s1 <= M1_W'(SEC_TENS_MAX)) && (ld_s2 <= DIG_W'(UNITS_MAX));
  end

  // Any load request, accepted or rejected, suppresses the tick on that edge.
  assign tc      = (presc == TC);
  assign ld_take = load & ld_ok;
  assign adv     = en & tc & ~load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (ld_take) begin
      presc <= '0;
    end else if (en && !load) begin
      presc <= tc ? '0 : presc + PW'(1);
    end
  end

  bcd_digit_counter #(.W(DIG_W), .MAX(UNITS_MAX)) u_s2 (
    .clk(clk), .reset(reset), .inc(adv), .load(ld_take), .value(ld_s2),
    .digit(s2), .carry(s2_carry));
  bcd_digit_counter #(.W(M1_W), .MAX(SEC_TENS_MAX)) u_s1 (
    .clk(clk), .reset(reset), .inc(s2_carry), .load(ld_take), .value(ld_s1),
    .digit(s1), .carry(s1_carry));
  bcd_digit_counter #(.W(DIG_W), .MAX(UNITS_MAX)) u_m2 (
    .clk(clk), .reset(reset), .inc(s1_carry), .load(ld_take), .value(ld_m2),
    .digit(m2), .carry(m2_carry));
  bcd_digit_counter #(.W(M1_W), .MAX(SEC_TENS_MAX)) u_m1 (
    .clk(clk), .reset(reset), .inc(m2_carry), .load(ld_take), .value(ld_m1),
    .digit(m1), .carry(hour_inc));

  // 12-hour sequence runs 12,01..11 with pm flipping on the way into 12.
  always_comb begin
    h1_nxt   = h1;
    h2_nxt   = h2;
    pm_nxt   = pm_q;
    day_roll = 1'b0;
    if (MODE_24H) begin
      if (cur_hours == HOURS24_MAX) begin
        h1_nxt   = '0;
        h2_nxt   = '0;
        day_roll = 1'b1;
      end else if (h2 == DIG_W'(UNITS_MAX)) begin
        h1_nxt = h1 + H1_W'(1);
        h2_nxt = '0;
      end else begin
        h2_nxt = h2 + DIG_W'(1);
      end
    end else begin
      if (cur_hours == HOURS12_MAX) begin
        h1_nxt = '0;
        h2_nxt = DIG_W'(1);
      end else if (cur_hours == HOURS12_MAX - 1) begin
        h1_nxt   = RST12_H1;
        h2_nxt   = RST12_H2;
        pm_nxt   = ~pm_q;
        day_roll = pm_q;
      end else if (h2 == DIG_W'(UNITS_MAX)) begin
        h1_nxt = h1 + H1_W'(1);
        h2_nxt = '0;
      end else begin
        h2_nxt = h2 + DIG_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1   <= MODE_24H ? RST24_H1 : RST12_H1;
      h2   <= MODE_24H ? RST24_H2 : RST12_H2;
      pm_q <= RST_PM;
    end else if (ld_take) begin
      h1   <= ld_h1;
      h2   <= ld_h2;
      pm_q <= MODE_24H ? 1'b0 : ld_pm;
    end else if (hour_inc) begin
      h1   <= h1_nxt;
      h2   <= h2_nxt;
      pm_q <= pm_nxt;
    end
  end

  // p1: pulses registered one cycle behind the edge that caused them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_tick_p1 <= 1'b0;
      day_tick_p1 <= 1'b0;
      load_err_p1 <= 1'b0;
    end else begin
      sec_tick_p1 <= adv;
      day_tick_p1 <= hour_inc & day_roll;
      load_err_p1 <= load & ~ld_ok;
    end
  end

  assign pm       = MODE_24H ? 1'b0 : pm_q;
  assign sec_tick = sec_tick_p1;
  assign day_tick = day_tick_p1;
  assign load_err = load_err_p1;

endmodule

// File: tb/tb_hms_bcd_counter.sv
// Bench for hms_bcd_counter: a 24-hour and a 12-hour instance share stimulus and a seconds-of-day model.
module tb_hms_bcd_counter;

  localparam int T = 4;

  logic       clk = 1'b1;
  logic       reset, en, load, ld_pm;
  logic [1:0] ld_h1;
  logic [3:0] ld_h2, ld_m2, ld_s2;
  logic [2:0] ld_m1, ld_s1;

  logic [1:0] h1_24, h1_12;
  logic [3:0] h2_24, h2_12, m2_24, m2_12, s2_24, s2_12;
  logic [2:0] m1_24, m1_12, s1_24, s1_12;
  logic       pm_24, pm_12, sec_24, sec_12, day_24, day_12, err_24, err_12;

  always #5 clk = ~clk;

  hms_bcd_counter #(.TICKS_PER_SEC(T), .MODE_24H(1'b1)) dut24 (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .ld_h1(ld_h1), .ld_h2(ld_h2), .ld_m1(ld_m1), .ld_m2(ld_m2), .ld_s1(ld_s1), .ld_s2(ld_s2),
    .ld_pm(ld_pm), .h1(h1_24), .h2(h2_24), .m1(m1_24), .m2(m2_24), .s1(s1_24), .s2(s2_24),
    .pm(pm_24), .sec_tick(sec_24), .day_tick(day_24), .load_err(err_24));

  hms_bcd_counter #(.TICKS_PER_SEC(T), .MODE_24H(1'b0)) dut12 (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .ld_h1(ld_h1), .ld_h2(ld_h2), .ld_m1(ld_m1), .ld_m2(ld_m2), .ld_s1(ld_s1), .ld_s2(ld_s2),
    .ld_pm(ld_pm), .h1(h1_12), .h2(h2_12), .m1(m1_12), .m2(m2_12), .s1(s1_12), .s2(s2_12),
    .pm(pm_12), .sec_tick(sec_12), .day_tick(day_12), .load_err(err_12));

  logic [23:0] obs24, obs12;
  assign obs24 = {h1_24, h2_24, m1_24, m2_24, s1_24, s2_24, pm_24, sec_24, day_24, err_24};
  assign obs12 = {h1_12, h2_12, m1_12, m2_12, s1_12, s2_12, pm_12, sec_12, day_12, err_12};

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: index 1 = 24-hour instance, 0 = 12-hour instance; time kept as seconds of day.
  int secs[2];
  int presc[2];
  bit e_sec[2], e_day[2], e_err[2];

  function automatic bit ld_valid(int m);
    int hrs = 10 * int'(ld_h1) + int'(ld_h2);
    bit ok = ld_h2 <= 9 && ld_m1 <= 5 && ld_m2 <= 9 && ld_s1 <= 5 && ld_s2 <= 9;
    if (m == 1) return ok && hrs <= 23;
    return ok && hrs >= 1 && hrs <= 12;
  endfunction

  function automatic int ld_secs(int m);
    int hrs = 10 * int'(ld_h1) + int'(ld_h2);
    int h24 = (m == 1) ? hrs : (hrs % 12) + (ld_pm ? 12 : 0);
    return h24 * 3600 + (10 * int'(ld_m1) + int'(ld_m2)) * 60 + 10 * int'(ld_s1) + int'(ld_s2);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      secs[m] = 0; presc[m] = 0; e_sec[m] = 0; e_day[m] = 0; e_err[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      e_sec[m] = 0; e_day[m] = 0; e_err[m] = 0;
      if (load) begin
        if (ld_valid(m)) begin
          secs[m] = ld_secs(m);
          presc[m] = 0;
        end else begin
          e_err[m] = 1;
        end
      end else if (en) begin
        if (presc[m] == T - 1) begin
          presc[m] = 0;
          secs[m] = (secs[m] + 1) % 86400;
          e_sec[m] = 1;
          e_day[m] = (secs[m] == 0);
        end else begin
          presc[m]++;
        end
      end
    end
  endtask

  function automatic logic [23:0] exp_obs(int m);
    int h24 = secs[m] / 3600;
    int hd = (m == 1) ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
    int mm = (secs[m] / 60) % 60;
    int ss = secs[m] % 60;
    logic p = (m == 0) && (h24 >= 12);
    return {2'(hd / 10), 4'(hd % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10),
            p, e_sec[m], e_day[m], e_err[m]};
  endfunction

  function automatic int dec24();
    return 100000 * int'(h1_24) + 10000 * int'(h2_24) + 1000 * int'(m1_24)
         + 100 * int'(m2_24) + 10 * int'(s1_24) + int'(s2_24);
  endfunction

  function automatic int dec12();
    return 100000 * int'(h1_12) + 10000 * int'(h2_12) + 1000 * int'(m1_12)
         + 100 * int'(m2_12) + 10 * int'(s1_12) + int'(s2_12);
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check(string name);
    cmp({name, "/24h"}, 32'(obs24), 32'(exp_obs(1)));
    cmp({name, "/12h"}, 32'(obs12), 32'(exp_obs(0)));
  endtask

  task automatic tick(string name);
    @(posedge clk);
    if (reset) model_step();
    #1;
    check(name);
  endtask

  task automatic set_ld(int a, int b, int c, int d, int e, int f, int p);
    ld_h1 = 2'(a); ld_h2 = 4'(b); ld_m1 = 3'(c); ld_m2 = 4'(d); ld_s1 = 3'(e); ld_s2 = 4'(f);
    ld_pm = p[0];
  endtask

  typedef struct {
    int h1, h2, m1, m2, s1, s2;
    bit err24, err12;
  } ld_vec_t;

  ld_vec_t tbl[12];

  initial begin
    int nticks, snap, guard, gap;

    tbl[0]  = '{2, 4, 0, 0, 0, 0, 1'b1, 1'b1};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 1'b0, 1'b1};
    tbl[2]  = '{0, 0, 6, 0, 0, 0, 1'b1, 1'b1};
    tbl[3]  = '{1, 2, 0, 0, 0, 0, 1'b0, 1'b0};
    tbl[4]  = '{1, 3, 0, 0, 0, 0, 1'b0, 1'b1};
    tbl[5]  = '{0, 0, 0, 0, 6, 0, 1'b1, 1'b1};
    tbl[6]  = '{0, 9, 5, 9, 5, 9, 1'b0, 1'b0};
    tbl[7]  = '{2, 3, 5, 9, 5, 9, 1'b0, 1'b1};
    tbl[8]  = '{1, 9, 0, 0, 0, 0, 1'b0, 1'b1};
    tbl[9]  = '{0, 1, 0, 0, 0, 10, 1'b1, 1'b1};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 1'b0, 1'b0};
    tbl[11] = '{3, 0, 0, 0, 0, 0, 1'b1, 1'b1};

    reset = 1'b0; en = 1'b0; load = 1'b0;
    set_ld(0, 0, 0, 0, 0, 0, 0);
    #12;
    model_reset();
    check("reset_state");
    cmp("reset_12h_time", 32'(dec12()), 32'd120000);
    #3 reset = 1'b1;

    // Free run from reset: ten seconds in forty cycles.
    en = 1'b1;
    nticks = 0;
    for (int i = 0; i < 40; i++) begin
      tick("run40");
      if (sec_24) nticks++;
    end
    cmp("t1_tick_count", 32'(nticks), 32'd10);
    cmp("t1_time", 32'(dec24()), 32'd10);

    // Midnight rollover in 24-hour mode.
    set_ld(2, 3, 5, 9, 5, 8, 0); load = 1'b1;
    tick("t2_load");
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick("t2_run");
    cmp("t2_235959", 32'(dec24()), 32'd235959);
    for (int i = 0; i < 4; i++) tick("t2_run");
    cmp("t2_midnight", 32'(dec24()), 32'd0);
    cmp("t2_sec_day", 32'({sec_24, day_24}), 32'b11);

    // Noon and midnight in 12-hour mode.
    set_ld(1, 1, 5, 9, 5, 9, 0); load = 1'b1;
    tick("t3_load_am");
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick("t3_run");
    cmp("t3_noon_time", 32'(dec12()), 32'd120000);
    cmp("t3_noon_pm_day", 32'({pm_12, day_12}), 32'b10);
    set_ld(1, 1, 5, 9, 5, 9, 1); load = 1'b1;
    tick("t3_load_pm");
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick("t3_run");
    cmp("t3_mid_time", 32'(dec12()), 32'd120000);
    cmp("t3_mid_pm_day", 32'({pm_12, day_12}), 32'b01);

    // Load validation table, clock stopped.
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      snap = dec24();
      set_ld(tbl[i].h1, tbl[i].h2, tbl[i].m1, tbl[i].m2, tbl[i].s1, tbl[i].s2, 0);
      load = 1'b1;
      tick("t4_load");
      load = 1'b0;
      cmp($sformatf("t4_err24_%0d", i), 32'(err_24), 32'(tbl[i].err24));
      cmp($sformatf("t4_err12_%0d", i), 32'(err_12), 32'(tbl[i].err12));
      if (tbl[i].err24) cmp($sformatf("t4_keep24_%0d", i), 32'(dec24()), 32'(snap));
      tick("t4_idle");
    end

    // Load on the terminal-count edge.
    en = 1'b1;
    set_ld(0, 1, 0, 0, 0, 0, 0); load = 1'b1;
    tick("t5_sync");
    load = 1'b0;
    guard = 0;
    while (presc[1] != T - 1 && guard < 10) begin
      tick("t5_wait");
      guard++;
    end
    set_ld(0, 5, 0, 5, 0, 5, 0); load = 1'b1;
    tick("t5_load");
    load = 1'b0;
    cmp("t5_time", 32'(dec24()), 32'd50505);
    cmp("t5_no_sec", 32'(sec_24), 32'd0);
    gap = 0;
    do begin
      tick("t5_gap_run");
      gap++;
    end while (!sec_24 && gap < 20);
    cmp("t5_gap", 32'(gap), 32'(T));

    // Freeze with en low, then asynchronous reset between edges.
    tick("t6_pre");
    en = 1'b0;
    snap = dec24();
    for (int i = 0; i < 20; i++) begin
      tick("t6_hold");
      cmp("t6_frozen", 32'(dec24()), 32'(snap));
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick("t6_resume");
    @(posedge clk);
    model_step();
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("t6_async_reset");
    cmp("t6_rst24_time", 32'(dec24()), 32'd0);
    cmp("t6_rst12_time", 32'(dec12()), 32'd120000);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) < 8);
      load = ($urandom_range(0, 19) == 0);
      if (load)
        set_ld($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 6),
               $urandom_range(0, 10), $urandom_range(0, 6), $urandom_range(0, 10),
               $urandom_range(0, 1));
      tick("rand");
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
